// File: rtl/spi_regctl_pkg.sv
// Shared constants for the SPI-driven register bus controller.
package spi_regctl_pkg;

   localparam int unsigned WORDSIZE_DEF = 8;
   localparam int unsigned RW_BIT       = WORDSIZE_DEF - 1;
   localparam int unsigned STATE_W      = 3;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CMD     = 3'd1;
   localparam logic [2:0] ST_WR_WAIT = 3'd2;
   localparam logic [2:0] ST_WR_BUS  = 3'd3;
   localparam logic [2:0] ST_RD_BUS  = 3'd4;
   localparam logic [2:0] ST_RD_WAIT = 3'd5;

   // Position of the read/write flag in a command word of the given width.
   function automatic int unsigned rw_bit_of(input int unsigned wordsize);
      return wordsize - 1;
   endfunction

endpackage

// File: rtl/spi_slave_regctl_if.sv
// Register bus between the SPI controller (master) and the register file (slave).
interface spi_slave_regctl_if #(
   parameter int unsigned WORDSIZE  = 8,
   parameter int unsigned ADDR_BITS = 7
);
   logic [ADDR_BITS-1:0] reg_addr;
   logic [WORDSIZE-1:0]  reg_wdata;
   logic                 reg_we;
   logic                 reg_re;
   logic [WORDSIZE-1:0]  reg_rdata;
   logic                 reg_ack;

   modport master (
      output reg_addr, reg_wdata, reg_we, reg_re,
      input  reg_rdata, reg_ack
   );

   modport slave (
      input  reg_addr, reg_wdata, reg_we, reg_re,
      output reg_rdata, reg_ack
   );
endinterface

// File: rtl/spi_slave_regctl_ss_sync.sv
// Two-flop synchronizer for the raw slave select, preset to inactive (1).
module spi_slave_regctl_ss_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   // Double-register the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/spi_slave_regctl.sv
// Turns received SPI words into register bus writes and prefetching reads.
module spi_slave_regctl
   import spi_regctl_pkg::*;
#(
   parameter int unsigned WORDSIZE  = 8,
   parameter int unsigned ADDR_BITS = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ss,
   input  logic                rx_irq,
   input  logic [WORDSIZE-1:0] rx_data,
   output logic [WORDSIZE-1:0] tx_data,
   output logic                frame_active,
   output logic                err_overrun,
   spi_slave_regctl_if.master  bus
);
   localparam int unsigned RW_POS = rw_bit_of(WORDSIZE);

   logic                 ss_s;
   logic [2:0]           state, state_nxt;
   logic [WORDSIZE-1:0]  tx_nxt, wdata_nxt;
   logic [ADDR_BITS-1:0] addr_nxt;
   logic                 we_nxt, re_nxt, ovr_nxt, close_nxt, close_pend;

   spi_slave_regctl_ss_sync ss_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ss),
      .q     (ss_s)
   );

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         tx_data       <= '0;
         bus.reg_addr  <= '0;
         bus.reg_wdata <= '0;
         bus.reg_we    <= 1'b0;
         bus.reg_re    <= 1'b0;
         frame_active  <= 1'b0;
         err_overrun   <= 1'b0;
         close_pend    <= 1'b0;
      end else begin
         state         <= state_nxt;
         tx_data       <= tx_nxt;
         bus.reg_addr  <= addr_nxt;
         bus.reg_wdata <= wdata_nxt;
         bus.reg_we    <= we_nxt;
         bus.reg_re    <= re_nxt;
         frame_active  <= (state_nxt != ST_IDLE);
         err_overrun   <= ovr_nxt;
         close_pend    <= close_nxt;
      end
   end

   // Next-state and next-output decode; a frame end during a bus cycle waits for the ack.
   always_comb begin
      state_nxt = state;
      tx_nxt    = tx_data;
      addr_nxt  = bus.reg_addr;
      wdata_nxt = bus.reg_wdata;
      we_nxt    = bus.reg_we;
      re_nxt    = bus.reg_re;
      ovr_nxt   = err_overrun;
      close_nxt = close_pend;

      case (state)
         ST_IDLE: begin
            if (!ss_s) state_nxt = ST_CMD;
         end
         ST_CMD: begin
            if (ss_s) begin
               state_nxt = ST_IDLE;
            end else if (rx_irq) begin
               addr_nxt = rx_data[ADDR_BITS-1:0];
               if (rx_data[RW_POS]) begin
                  state_nxt = ST_RD_BUS;
                  re_nxt    = 1'b1;
               end else begin
                  state_nxt = ST_WR_WAIT;
               end
            end
         end
         ST_WR_WAIT: begin
            if (ss_s) begin
               state_nxt = ST_IDLE;
            end else if (rx_irq) begin
               wdata_nxt = rx_data;
               we_nxt    = 1'b1;
               state_nxt = ST_WR_BUS;
            end
         end
         ST_WR_BUS: begin
            if (ss_s)        close_nxt = 1'b1;
            else if (rx_irq) ovr_nxt   = 1'b1;
            if (bus.reg_ack) begin
               we_nxt = 1'b0;
               if (ss_s || close_pend) begin
                  state_nxt = ST_IDLE;
               end else begin
                  addr_nxt  = bus.reg_addr + ADDR_BITS'(1);
                  state_nxt = ST_WR_WAIT;
               end
            end
         end
         ST_RD_BUS: begin
            if (ss_s)        close_nxt = 1'b1;
            else if (rx_irq) ovr_nxt   = 1'b1;
            if (bus.reg_ack) begin
               re_nxt = 1'b0;
               if (ss_s || close_pend) begin
                  state_nxt = ST_IDLE;
               end else begin
                  tx_nxt    = bus.reg_rdata;
                  addr_nxt  = bus.reg_addr + ADDR_BITS'(1);
                  state_nxt = ST_RD_WAIT;
               end
            end
         end
         ST_RD_WAIT: begin
            if (ss_s) begin
               state_nxt = ST_IDLE;
            end else if (rx_irq) begin
               re_nxt    = 1'b1;
               state_nxt = ST_RD_BUS;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (state_nxt == ST_IDLE) begin
         tx_nxt    = '0;
         close_nxt = 1'b0;
      end
   end
endmodule

// File: tb/tb_spi_slave_regctl.sv
// Randomized bench with a frame-level reference model and a 2-cycle-ack register responder.
module tb_spi_slave_regctl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ss = 1'b1;
   logic       rx_irq = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [7:0] tx_data;
   logic       frame_active, err_overrun;

   spi_slave_regctl_if #(.WORDSIZE(8), .ADDR_BITS(7)) bif ();

   spi_slave_regctl #(.WORDSIZE(8), .ADDR_BITS(7)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ss           (ss),
      .rx_irq       (rx_irq),
      .rx_data      (rx_data),
      .tx_data      (tx_data),
      .frame_active (frame_active),
      .err_overrun  (err_overrun),
      .bus          (bif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] bus_mem [128];
   logic [7:0] ref_mem [128];
   int  wr_q[$];
   int  rd_q[$];
   int  fdata[$];
   bit  ack_en = 1'b1;
   int  lat = 0;
   bit  both_high = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   // Register file: ack 2 cycles after a request rises, one-cycle ack pulse.
   always @(negedge clk) begin
      if (bif.reg_we && bif.reg_re) both_high = 1'b1;
      if (!rst_n) begin
         bif.reg_ack = 1'b0;
         lat = 0;
      end else if ((bif.reg_we || bif.reg_re) && !bif.reg_ack) begin
         lat++;
         if (lat >= 2 && ack_en) begin
            bif.reg_ack = 1'b1;
            lat = 0;
            if (bif.reg_we) begin
               bus_mem[bif.reg_addr] = bif.reg_wdata;
               wr_q.push_back(32'({bif.reg_addr, bif.reg_wdata}));
            end else begin
               bif.reg_rdata = bus_mem[bif.reg_addr];
               rd_q.push_back(32'(bif.reg_addr));
            end
         end
      end else begin
         bif.reg_ack = 1'b0;
         lat = 0;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_word(input logic [7:0] w);
      @(negedge clk);
      rx_irq  = 1'b1;
      rx_data = w;
      @(negedge clk);
      rx_irq  = 1'b0;
      cycles(8);
   endtask

   task automatic start_frame();
      ss = 1'b0;
      cycles(4);
      wr_q.delete();
      rd_q.delete();
   endtask

   // One frame: command then the words in fdata; expectations from address arithmetic.
   task automatic run_frame(input bit rd, input int a);
      int exp_wr[$];
      int exp_rd[$];
      int ad;
      start_frame();
      check("frame_active_low_ss", 32'(frame_active), 32'd1);
      send_word(8'({rd, 7'(a)}));
      if (rd) begin
         exp_rd.push_back(a);
         check("rd_tx_after_cmd", 32'(tx_data), 32'(ref_mem[a]));
      end
      for (int i = 0; i < fdata.size(); i++) begin
         ad = (a + i + (rd ? 1 : 0)) % 128;
         send_word(8'(fdata[i]));
         if (rd) begin
            exp_rd.push_back(ad);
            check("rd_tx_after_word", 32'(tx_data), 32'(ref_mem[ad]));
         end else begin
            ref_mem[ad] = 8'(fdata[i]);
            exp_wr.push_back((ad << 8) | (fdata[i] & 8'hFF));
         end
      end
      ss = 1'b1;
      cycles(6);
      check("frame_end_idle", 32'(frame_active), 32'd0);
      check("frame_end_tx_zero", 32'(tx_data), 32'd0);
      check("no_overrun", 32'(err_overrun), 32'd0);
      check("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
         check("wr_entry", 32'(wr_q[i]), 32'(exp_wr[i]));
      check("rd_count", 32'(rd_q.size()), 32'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
         check("rd_addr", 32'(rd_q[i]), 32'(exp_rd[i]));
   endtask

   initial begin
      bif.reg_ack   = 1'b0;
      bif.reg_rdata = 8'h00;
      for (int i = 0; i < 128; i++) begin
         bus_mem[i] = 8'($urandom);
         ref_mem[i] = bus_mem[i];
      end
      cycles(3);
      check("rst_tx", 32'(tx_data), 32'd0);
      check("rst_addr", 32'(bif.reg_addr), 32'd0);
      check("rst_we_re", 32'({bif.reg_we, bif.reg_re}), 32'd0);
      check("rst_active_ovr", 32'({frame_active, err_overrun}), 32'd0);
      rst_n = 1'b1;
      cycles(3);
      check("idle_ss_high", 32'(frame_active), 32'd0);

      // Write burst 0x05: 0xAA, 0xBB
      fdata = '{8'hAA, 8'hBB};
      run_frame(1'b0, 7'h05);

      // Read burst at 0x10 with two dummies
      bus_mem[8'h10] = 8'h11; ref_mem[8'h10] = 8'h11;
      bus_mem[8'h11] = 8'h22; ref_mem[8'h11] = 8'h22;
      fdata = '{8'h00, 8'h00};
      run_frame(1'b1, 7'h10);

      // Address wrap on writes and reads
      fdata = '{8'h3C, 8'hC3};
      run_frame(1'b0, 7'h7F);
      fdata = '{8'h5A};
      run_frame(1'b1, 7'h7F);

      // Random frames
      for (int f = 0; f < 8; f++) begin
         int n;
         n = int'($urandom_range(1, 4));
         fdata.delete();
         for (int i = 0; i < n; i++) fdata.push_back(int'($urandom_range(0, 255)));
         run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)));
      end

      // Overrun: second word arrives while the write is still unacknowledged
      start_frame();
      send_word(8'h03);
      ack_en = 1'b0;
      send_word(8'h44);
      check("ovr_we_held", 32'(bif.reg_we), 32'd1);
      send_word(8'h55);
      check("ovr_flag", 32'(err_overrun), 32'd1);
      ack_en = 1'b1;
      cycles(8);
      check("ovr_one_write", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) check("ovr_write_val", 32'(wr_q[0]), 32'h0344);
      ref_mem[3] = 8'h44;
      ss = 1'b1;
      cycles(6);
      check("ovr_sticky", 32'(err_overrun), 32'd1);
      check("ovr_idle", 32'(frame_active), 32'd0);

      // Frame end during RD_BUS: request held to completion, no increment
      start_frame();
      ack_en = 1'b0;
      send_word(8'hB0);
      check("abort_re_high", 32'(bif.reg_re), 32'd1);
      ss = 1'b1;
      cycles(6);
      check("abort_re_held", 32'(bif.reg_re), 32'd1);
      check("abort_still_active", 32'(frame_active), 32'd1);
      ack_en = 1'b1;
      cycles(6);
      check("abort_re_low", 32'(bif.reg_re), 32'd0);
      check("abort_idle", 32'(frame_active), 32'd0);
      check("abort_tx_zero", 32'(tx_data), 32'd0);
      check("abort_addr_kept", 32'(bif.reg_addr), 32'h30);
      check("abort_one_read", 32'(rd_q.size()), 32'd1);

      // Asynchronous reset mid-write
      start_frame();
      ack_en = 1'b0;
      send_word(8'h20);
      send_word(8'h77);
      check("arst_we_before", 32'(bif.reg_we), 32'd1);
      check("arst_addr_before", 32'(bif.reg_addr), 32'h20);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_we_re", 32'({bif.reg_we, bif.reg_re}), 32'd0);
      check("arst_addr_wdata", 32'({bif.reg_addr, bif.reg_wdata}), 32'd0);
      check("arst_tx", 32'(tx_data), 32'd0);
      check("arst_active_ovr", 32'({frame_active, err_overrun}), 32'd0);
      ss = 1'b1;
      ack_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      cycles(4);
      check("arst_no_write", 32'(wr_q.size()), 32'd0);
      check("we_re_exclusive", 32'(both_high), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/spi_slave_regctl.md
SPI_SLAVE_REGCTL -- requirements
Module: spi_slave_regctl

Interface
REQ-001 Parameter WORDSIZE, default 8: SPI word width in bits; legal range 2..32.
REQ-002 Parameter ADDR_BITS, default 7: register address width; legal range 1..WORDSIZE-1.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port ss, input, 1: raw SPI slave select, active-low, unsynchronized.
REQ-006 Port rx_irq, input, 1: one-cycle pulse from the SPI slave; a word has been received.
REQ-007 Port rx_data, input, WORDSIZE: received word, valid while rx_irq is high.
REQ-008 Port tx_data, output, WORDSIZE: word for the SPI slave to shift out next.
REQ-009 Port reg_addr, output, ADDR_BITS: register bus address.
REQ-010 Port reg_wdata, output, WORDSIZE: register bus write data.
REQ-011 Port reg_we, output, 1: write request; level, held until acknowledged.
REQ-012 Port reg_re, output, 1: read request; level, held until acknowledged.
REQ-013 Port reg_rdata, input, WORDSIZE: read data, valid in the reg_ack cycle.
REQ-014 Port reg_ack, input, 1: completes the pending request; sampled only while reg_we or reg_re is high.
REQ-015 Port frame_active, output, 1: high in any state other than IDLE.
REQ-016 Port err_overrun, output, 1: sticky; cleared only by reset.

Function
REQ-017 ss SHALL be synchronized through 2 flops; ss_s low means the frame is active.
REQ-018 States SHALL be: IDLE, CMD, WR_WAIT, WR_BUS, RD_BUS, RD_WAIT.
REQ-019 IDLE: ss_s low -> CMD; tx_data = 0.
REQ-020 CMD, on rx_irq: latch reg_addr = rx_data[ADDR_BITS-1:0]; rx_data[WORDSIZE-1]=1 -> RD_BUS, =0 -> WR_WAIT.
REQ-021 WR_WAIT, on rx_irq: reg_wdata <= rx_data, reg_we <= 1, go to WR_BUS.
REQ-022 WR_BUS, on reg_ack: reg_we <= 0, reg_addr increments, go to WR_WAIT.
REQ-023 RD_BUS: reg_re high. On reg_ack: tx_data <= reg_rdata, reg_re <= 0, reg_addr increments, go to RD_WAIT.
REQ-024 RD_WAIT, on rx_irq: rx_data is discarded; go to RD_BUS (next prefetch).
REQ-025 reg_we/reg_re SHALL rise the cycle after the triggering event and fall the cycle after reg_ack; they are never both high.
REQ-026 reg_addr increment SHALL wrap modulo 2^ADDR_BITS (all ones -> 0).
REQ-027 rx_irq while in WR_BUS or RD_BUS: set err_overrun, drop the word, stay in state.
REQ-028 ss_s high while in WR_BUS or RD_BUS: complete the pending request (wait for reg_ack, no address increment), then go to IDLE.
REQ-029 ss_s high in any other non-IDLE state: go to IDLE the next cycle.
REQ-030 ss_s high and rx_irq in the same cycle: ss_s takes precedence; the word is ignored.
REQ-031 tx_data SHALL clear to 0 on entry to IDLE; tx_data is otherwise changed only by REQ-023.
REQ-032 Read latency: the SPI master SHALL allow at least reg-ack latency + 3 clk between the end of a word and the first sample edge of the next word; this is a system-level constraint, not a block check.

Reset
REQ-033 rst_n low SHALL asynchronously force: state IDLE, tx_data 0, reg_addr 0, reg_wdata 0, reg_we 0, reg_re 0, frame_active 0, err_overrun 0, ss synchronizer flops 1.

Structure
REQ-034 The state enumeration and RW_BIT = WORDSIZE-1 SHALL live in the shared package spi_regctl_pkg.
REQ-035 The ss synchronizer SHALL be one sub-module instance, ss_sync, with an rst_n preset to 1.

Verification (WORDSIZE=8, ADDR_BITS=7, reg_ack 2 clk after request)
REQ-036 Write burst: ss low, words 0x05, 0xAA, 0xBB, ss high -> writes (0x05, 0xAA) then (0x06, 0xBB); FSM returns to IDLE.
REQ-037 Read burst: memory[0x10]=0x11, memory[0x11]=0x22; words 0x90, dummy, dummy -> tx_data 0x11 after the command, 0x22 after the first dummy; a third read is issued at 0x12.
REQ-038 Wrap: command 0x7F, two write words -> write addresses 0x7F then 0x00.
REQ-039 Overrun: rx_irq during WR_BUS with reg_ack withheld -> err_overrun=1, word dropped, exactly 1 write seen.
REQ-040 ss rises during RD_BUS -> reg_re held until reg_ack, then IDLE, tx_data=0, reg_addr unchanged.
REQ-041 rst_n pulsed low mid-write (reg_we=1) -> all outputs 0 at once, with no clk edge required.
